in_ram_loader: RTL and testbench

- Serial-to-parallel writer that fills the input RAM before the datapath starts reading it.
- Accepts a bit stream, MSB first, over a valid/ready handshake and assembles DATA_WIDTH-bit words in a shift register.
- Writes words to consecutive RAM addresses 0..NUM_WORDS-1, then raises done so the main controller can start processing.

---
 rtl/in_ram_loader.sv | 155 +++++++++++++++
 tb/tb_in_ram_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/in_ram_loader.sv
// Loads the input RAM from an MSB-first bit stream. A word is written one cycle after its last bit is accepted.
// ser_ready is low in every state except SHIFT. Define IN_RAM_LOADER_PARITY_EN to expect an even-parity bit after each word.
module in_ram_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WORDS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ser_in,
    input  logic                  ser_valid,
    output logic                  ser_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  par_err
);

`ifdef IN_RAM_LOADER_PARITY_EN
    localparam int BITS_PER_WORD = DATA_WIDTH + 1;
`else
    localparam int BITS_PER_WORD = DATA_WIDTH;
`endif
    localparam int BCW = $clog2(BITS_PER_WORD + 1);
    localparam logic [BCW-1:0]        LAST_BIT  = BCW'(BITS_PER_WORD - 1);
    localparam logic [BCW-1:0]        DATA_BITS = BCW'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ser_ready  = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    state_d    = S_SHIFT;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_SHIFT: begin
                ser_ready = 1'b1;
                busy      = 1'b1;
                if (ser_valid) begin
                    // A trailing parity bit is counted but never enters the data word.
                    if (bit_cnt_q < DATA_BITS) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], ser_in};
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_WRITE;
                        addr_d    = word_cnt_q;
                        data_d    = shreg_d;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            S_WRITE: begin
                wr_en      = 1'b1;
                busy       = 1'b1;
                word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                state_d    = (word_cnt_q == LAST_WORD) ? S_DONE : S_SHIFT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_addr = addr_q;
    assign wr_data = data_q;

`ifdef IN_RAM_LOADER_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic par_err_q, par_err_d;
    logic load_start, bit_take, last_take;

    assign load_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign bit_take   = (state_q == S_SHIFT) && ser_valid;
    assign last_take  = bit_take && (bit_cnt_q == LAST_BIT);

    // The error flag updates on the edge into WRITE so it is visible with that word's wr_en.
    always_comb begin
        par_acc_d = par_acc_q;
        par_err_d = par_err_q;
        if (load_start) begin
            par_acc_d = 1'b0;
            par_err_d = 1'b0;
        end else if (last_take) begin
            par_acc_d = 1'b0;
            par_err_d = par_err_q | (par_acc_q ^ ser_in);
        end else if (bit_take) begin
            par_acc_d = par_acc_q ^ ser_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_in_ram_loader.sv
// Scoreboarded random bench for in_ram_loader, plus a one-word instance sharing the same stream.
module tb_in_ram_loader;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NW = 16;
`ifdef IN_RAM_LOADER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BPW = DW + (PAR ? 1 : 0);

    logic clk = 1'b0;
    logic rst, start, ser_in, ser_valid;
    logic ser_ready, wr_en, busy, done, par_err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic o1_ser_ready, o1_wr_en, o1_busy, o1_done, o1_par_err;
    logic [AW-1:0] o1_wr_addr;
    logic [DW-1:0] o1_wr_data;

    in_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .par_err(par_err)
    );

    in_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_ready(o1_ser_ready), .wr_en(o1_wr_en), .wr_addr(o1_wr_addr), .wr_data(o1_wr_data),
        .busy(o1_busy), .done(o1_done), .par_err(o1_par_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit stuck = 1'b0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Expected RAM writes in issue order, with the sticky error expected on each.
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    logic          q_perr[$];
    logic [DW-1:0] words[NW];
    bit            badpar[NW];
    bit            model_perr;

    always @(negedge clk) begin : monitor
        if (!rst && wr_en) begin
            if (q_addr.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                chk("wr_addr", wr_addr, q_addr.pop_front());
                chk("wr_data", wr_data, q_data.pop_front());
                chk("par_err_at_write", par_err, q_perr.pop_front());
                chk("ready_low_in_write", ser_ready, 1'b0);
            end
        end
    end

    int            u1_writes = 0;
    logic [DW-1:0] u1_first = '0;
    bit            u1_prev_wr = 1'b0;
    always @(negedge clk) begin : monitor_u1
        if (u1_prev_wr) begin
            chk("u1_done_after_write", o1_done, 1'b1);
            chk("u1_idle_in_done", {o1_busy, o1_ser_ready}, 2'b00);
        end
        if (!rst && o1_wr_en) begin
            chk("u1_addr", o1_wr_addr, '0);
            if (u1_writes == 0) u1_first = o1_wr_data;
            u1_writes++;
        end
        u1_prev_wr = !rst && o1_wr_en;
    end

    task automatic send_bit(input logic b, input bit gaps);
        int k;
        if (stuck) return;
        if (gaps && $urandom_range(0, 1) == 1) begin
            ser_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        ser_valid = 1'b1;
        ser_in    = b;
        k = 0;
        while (!ser_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ser_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            stuck = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ser_ready"}, ser_ready, 1'b0);
        chk({tag, "_wr_en"}, wr_en, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_par_err"}, par_err, 1'b0);
        chk({tag, "_wr_addr"}, wr_addr, '0);
        chk({tag, "_wr_data"}, wr_data, '0);
    endtask

    task automatic run_load(input bit gaps, input bit start_mid, input int abort_word, input bit timed);
        int t0;
        int k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_done_low", done, 1'b0);
        chk("start_par_err_clear", par_err, 1'b0);
        model_perr = 1'b0;
        t0 = cyc;
        for (int w = 0; w < NW; w++) begin
            if (w == abort_word) begin
                for (int b = DW - 1; b > DW - 8; b--) send_bit(words[w][b], gaps);
                rst       = 1'b1;
                ser_valid = 1'b0;
                @(negedge clk);
                check_zero("abort");
                chk("abort_pending_writes", q_addr.size(), 0);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            model_perr = model_perr | badpar[w];
            q_addr.push_back(AW'(w));
            q_data.push_back(words[w]);
            q_perr.push_back(model_perr);
            for (int b = DW - 1; b >= 0; b--) begin
                if (start_mid && w == 5 && b == 10) start = 1'b1;
                send_bit(words[w][b], gaps);
                start = 1'b0;
            end
            if (PAR) send_bit((^words[w]) ^ badpar[w], gaps);
        end
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("done_level", done, 1'b1);
        if (timed) chk("load_cycles", cyc - t0, NW * (BPW + 1));
        chk("done_busy_low", busy, 1'b0);
        chk("done_ready_low", ser_ready, 1'b0);
        chk("done_par_err", par_err, model_perr);
        chk("all_writes_seen", q_addr.size(), 0);
        ser_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_held", done, 1'b1);
    endtask

    task automatic fill_random(input bit allow_bad);
        for (int i = 0; i < NW; i++) begin
            words[i]  = DW'($urandom);
            badpar[i] = PAR && allow_bad && ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("u1_reset", {o1_ser_ready, o1_wr_en, o1_busy, o1_done, o1_par_err, o1_wr_addr, o1_wr_data},
            '0);
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Incrementing words, valid held high, cycle-exact completion.
        for (int i = 0; i < NW; i++) begin
            words[i]  = DW'(i + 1);
            badpar[i] = 1'b0;
        end
        run_load(1'b0, 1'b0, -1, 1'b1);
        chk("u1_single_write", u1_writes, 1);
        chk("u1_word", u1_first, 16'h0001);

        // Restart from DONE with gapped valid and a known pattern.
        fill_random(1'b1);
        words[0]  = 16'hA5C3;
        badpar[0] = 1'b0;
        words[1]  = 16'h0007;
        badpar[1] = PAR;
        run_load(1'b1, 1'b0, -1, 1'b0);

        // start pulsed while busy must be ignored.
        fill_random(1'b1);
        run_load(1'b0, 1'b1, -1, 1'b0);

        // Reset after 7 bits of word 3, then a fresh load.
        fill_random(1'b0);
        run_load(1'b0, 1'b0, 3, 1'b0);
        fill_random(1'b1);
        run_load(1'b1, 1'b0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
